// File: rtl/instr_field_decode.sv
// instr_field_decode
//   Decode/issue stage in front of the ALU source-1 extender. Classifies one
//   RV32 word per cycle as LW, SW, SRAI, LUI or illegal, slices out the
//   immediate and register fields, and presents them registered behind a
//   2-entry (output slot + skid slot) buffer so backpressure never drops
//   an instruction.
// Ports:
//   clk, rst_n         rising-edge clock, async active-low reset
//   in_valid/in_ready  input handshake, in_instr = instruction word
//   flush              synchronous discard of held and incoming entries
//   out_valid/ready    output handshake
//   out_op2            0 illegal, 1 LW, 2 SW, 3 SRAI, 4 LUI
//   out_imm12/imm20    immediate fields (unused one is zero)
//   out_rs1/rs2/rd     register addresses
//   out_reg_write      destination write enable
//   out_illegal        entry is not a supported instruction
//   illegal_count      saturating count of delivered illegal entries
module instr_field_decode (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_op2,
   output logic [11:0] out_imm12,
   output logic [19:0] out_imm20,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_illegal,
   output logic [7:0]  illegal_count
);

   typedef enum logic [4:0] {
      OP_NONE = 5'd0,
      OP_LW   = 5'd1,
      OP_SW   = 5'd2,
      OP_SRAI = 5'd3,
      OP_LUI  = 5'd4
   } op2_e;

   typedef struct packed {
      op2_e        op2;
      logic [11:0] imm12;
      logic [19:0] imm20;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } entry_t;

   entry_t      w_dec;
   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_in_fire;
   logic        w_out_fire;
   logic        w_out_load;

   entry_t      r_out;
   logic        r_out_valid;
   entry_t      r_skid;
   logic        r_skid_valid;
   logic [7:0]  r_illegal_count;

   assign w_opcode = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];

   always_comb begin
      w_dec = '0;
      if (w_opcode == 7'b0000011 && w_f3 == 3'b010) begin
         w_dec.op2       = OP_LW;
         w_dec.imm12     = in_instr[31:20];
         w_dec.rs1       = in_instr[19:15];
         w_dec.rd        = in_instr[11:7];
         w_dec.reg_write = 1'b1;
      end else if (w_opcode == 7'b0100011 && w_f3 == 3'b010) begin
         w_dec.op2       = OP_SW;
         w_dec.imm12     = {in_instr[31:25], in_instr[11:7]};
         w_dec.rs1       = in_instr[19:15];
         w_dec.rs2       = in_instr[24:20];
      end else if (w_opcode == 7'b0010011 && w_f3 == 3'b101 && w_f7 == 7'b0100000) begin
         w_dec.op2       = OP_SRAI;
         w_dec.imm12     = {7'b0, in_instr[24:20]};
         w_dec.rs1       = in_instr[19:15];
         w_dec.rd        = in_instr[11:7];
         w_dec.reg_write = 1'b1;
      end else if (w_opcode == 7'b0110111) begin
         w_dec.op2       = OP_LUI;
         w_dec.imm20     = in_instr[31:12];
         w_dec.rd        = in_instr[11:7];
         w_dec.reg_write = 1'b1;
      end else begin
         w_dec.illegal   = 1'b1;
      end
   end

   assign in_ready   = !r_skid_valid;
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = r_out_valid && out_ready;
   // Output slot may take a new entry when it is empty or being drained.
   assign w_out_load = w_out_fire || !r_out_valid;

   // The skid slot is only ever occupied while the output slot is, and
   // in_ready is low while it is, so a load from skid never races an input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_out_load) begin
         if (r_skid_valid) begin
            r_out        <= r_skid;
            r_out_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_in_fire) begin
            r_out        <= w_dec;
            r_out_valid  <= 1'b1;
         end else begin
            r_out_valid  <= 1'b0;
         end
      end else if (w_in_fire) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
      end
   end

   // Counts transfers even in a flush cycle; flush does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_count <= '0;
      end else if (w_out_fire && r_out.illegal && r_illegal_count != 8'hFF) begin
         r_illegal_count <= r_illegal_count + 8'd1;
      end
   end

   assign out_valid     = r_out_valid;
   assign out_op2       = r_out.op2;
   assign out_imm12     = r_out.imm12;
   assign out_imm20     = r_out.imm20;
   assign out_rs1       = r_out.rs1;
   assign out_rs2       = r_out.rs2;
   assign out_rd        = r_out.rd;
   assign out_reg_write = r_out.reg_write;
   assign out_illegal   = r_out.illegal;
   assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_instr_field_decode.sv
module tb_instr_field_decode;

   typedef struct packed {
      logic [4:0]  op2;
      logic [11:0] imm12;
      logic [19:0] imm20;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } dec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_op2;
   logic [11:0] out_imm12;
   logic [19:0] out_imm20;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_illegal;
   logic [7:0]  illegal_count;

   dec_t        dut_now;
   dec_t        q[$];
   logic [7:0]  ref_cnt;
   int          n_checks;
   int          n_errors;

   logic [31:0] words [4];
   logic [4:0]  k_op2 [4];
   logic [4:0]  k_rd  [4];

   instr_field_decode dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_op2       (out_op2),
      .out_imm12     (out_imm12),
      .out_imm20     (out_imm20),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_rd        (out_rd),
      .out_reg_write (out_reg_write),
      .out_illegal   (out_illegal),
      .illegal_count (illegal_count)
   );

   assign dut_now = {out_op2, out_imm12, out_imm20, out_rs1, out_rs2, out_rd,
                     out_reg_write, out_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // Reference decode written from the instruction-set rules with plain shifts.
   function automatic dec_t model(input logic [31:0] w);
      dec_t m;
      logic [31:0] opc, f3, f7, rd, rs1, rs2;
      opc = w & 32'h7F;
      f3  = (w >> 12) & 32'h7;
      f7  = w >> 25;
      rd  = (w >> 7) & 32'h1F;
      rs1 = (w >> 15) & 32'h1F;
      rs2 = (w >> 20) & 32'h1F;
      m = '0;
      if (opc == 32'd3 && f3 == 32'd2) begin
         m.op2 = 5'd1; m.imm12 = 12'(w >> 20); m.rs1 = 5'(rs1); m.rd = 5'(rd); m.rw = 1'b1;
      end else if (opc == 32'd35 && f3 == 32'd2) begin
         m.op2 = 5'd2; m.imm12 = 12'((f7 << 5) | rd); m.rs1 = 5'(rs1); m.rs2 = 5'(rs2);
      end else if (opc == 32'd19 && f3 == 32'd5 && f7 == 32'd32) begin
         m.op2 = 5'd3; m.imm12 = 12'(rs2); m.rs1 = 5'(rs1); m.rd = 5'(rd); m.rw = 1'b1;
      end else if (opc == 32'd55) begin
         m.op2 = 5'd4; m.imm20 = 20'(w >> 12); m.rd = 5'(rd); m.rw = 1'b1;
      end else begin
         m.ill = 1'b1;
      end
      return m;
   endfunction

   // Drives one cycle and advances the queue-occupancy model across the edge.
   task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic ordy,
                              input logic fl, output logic acc, output logic del);
      dec_t e;
      in_valid  = v;
      in_instr  = ins;
      out_ready = ordy;
      flush     = fl;
      acc = v && (q.size() < 2);
      del = ordy && (q.size() > 0);
      if (del) begin
         e = q.pop_front();
         if (e.ill && ref_cnt != 8'd255) ref_cnt = ref_cnt + 8'd1;
      end
      if (fl) q.delete();
      else if (acc) q.push_back(model(ins));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 4))
         0: return (r & 32'hFFFF8F80) | 32'h00002003;
         1: return (r & 32'hFFFF8F80) | 32'h00002023;
         2: return (r & 32'h01FF8F80) | 32'h40005013;
         3: return (r & 32'hFFFFFF80) | 32'h00000037;
         default: return r;
      endcase
   endfunction

   task automatic test_reset();
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++;
      if (illegal_count !== 8'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", illegal_count); end
      n_checks++;
      if (dut_now !== dec_t'('0)) begin n_errors++; $display("FAIL reset_fields got %h want 0", dut_now); end
   endtask

   task automatic test_decode();
      logic a, d;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, words[i], 1'b1, 1'b0, a, d);
         n_checks++;
         if (out_valid !== 1'b1 || q.size() != 1) begin
            n_errors++; $display("FAIL decode_valid[%0d] got %b want 1", i, out_valid);
         end else if (dut_now !== q[0]) begin
            n_errors++; $display("FAIL decode_fields[%0d] got %h want %h", i, dut_now, q[0]);
         end
         n_checks++;
         if (out_op2 !== k_op2[i] || out_rd !== k_rd[i]) begin
            n_errors++; $display("FAIL decode_known[%0d] got op2=%0d rd=%0d want op2=%0d rd=%0d",
                                 i, out_op2, out_rd, k_op2[i], k_rd[i]);
         end
      end
      drive_cycle(1'b0, '0, 1'b1, 1'b0, a, d);
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL decode_drain got %b want 0", out_valid); end
   endtask

   task automatic test_illegal();
      logic a, d;
      drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, a, d);
      n_checks++;
      if (out_illegal !== 1'b1 || out_op2 !== 5'd0 || out_reg_write !== 1'b0 ||
          out_imm12 !== 12'd0 || out_imm20 !== 20'd0) begin
         n_errors++; $display("FAIL illegal_fields got %h want ill=1 others 0", dut_now);
      end
      n_checks++;
      if (illegal_count !== 8'd0) begin n_errors++; $display("FAIL illegal_cnt_before got %0d want 0", illegal_count); end
      drive_cycle(1'b0, '0, 1'b1, 1'b0, a, d);
      n_checks++;
      if (illegal_count !== 8'd1) begin n_errors++; $display("FAIL illegal_cnt_after got %0d want 1", illegal_count); end
   endtask

   task automatic test_backpressure();
      logic a, d;
      int k, delivered, cyc;
      k = 0;
      for (int c = 0; c < 5; c++) begin
         drive_cycle(1'b1, words[k], 1'b0, 1'b0, a, d);
         if (a) k++;
         if (q.size() > 0) begin
            n_checks++;
            if (dut_now !== q[0]) begin n_errors++; $display("FAIL bp_stable got %h want %h", dut_now, q[0]); end
         end
      end
      n_checks++;
      if (k != 2 || in_ready !== 1'b0) begin
         n_errors++; $display("FAIL bp_accepted got k=%0d in_ready=%b want k=2 in_ready=0", k, in_ready);
      end
      delivered = 0;
      cyc = 0;
      while ((k < 4 || q.size() > 0) && cyc < 20) begin
         n_checks++;
         if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
            n_errors++; $display("FAIL bp_flags got v=%b r=%b want v=%b r=%b", out_valid, in_ready,
                                 q.size() != 0, q.size() < 2);
         end else if (q.size() != 0 && dut_now !== q[0]) begin
            n_errors++; $display("FAIL bp_order got %h want %h", dut_now, q[0]);
         end
         drive_cycle(k < 4, (k < 4) ? words[k] : 32'd0, 1'b1, 1'b0, a, d);
         if (a) k++;
         if (d) delivered++;
         cyc++;
      end
      n_checks++;
      if (delivered != 4 || out_valid !== 1'b0) begin
         n_errors++; $display("FAIL bp_delivered got %0d valid=%b want 4 valid=0", delivered, out_valid);
      end
   endtask

   task automatic test_flush();
      logic a, d;
      drive_cycle(1'b1, words[0], 1'b0, 1'b0, a, d);
      drive_cycle(1'b1, words[1], 1'b0, 1'b0, a, d);
      drive_cycle(1'b1, words[2], 1'b0, 1'b1, a, d);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++; $display("FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
      drive_cycle(1'b1, words[0], 1'b0, 1'b0, a, d);
      drive_cycle(1'b1, words[3], 1'b0, 1'b1, a, d);
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_handshake[%0d] got v=%b r=%b want v=0 r=1", c, out_valid, in_ready);
         end
         drive_cycle(1'b0, '0, 1'b1, 1'b0, a, d);
      end
      drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, a, d);
      drive_cycle(1'b0, '0, 1'b1, 1'b1, a, d);
      n_checks++;
      if (illegal_count !== ref_cnt || out_valid !== 1'b0) begin
         n_errors++; $display("FAIL flush_with_xfer got cnt=%0d v=%b want cnt=%0d v=0",
                              illegal_count, out_valid, ref_cnt);
      end
   endtask

   task automatic test_random(input int cycles);
      logic a, d;
      for (int c = 0; c < cycles; c++) begin
         n_checks++;
         if (out_valid !== (q.size() != 0)) begin
            n_errors++; $display("FAIL rand_valid[%0d] got %b want %b", c, out_valid, q.size() != 0);
         end else if (in_ready !== (q.size() < 2)) begin
            n_errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, in_ready, q.size() < 2);
         end else if (q.size() != 0 && dut_now !== q[0]) begin
            n_errors++; $display("FAIL rand_fields[%0d] got %h want %h", c, dut_now, q[0]);
         end else if (illegal_count !== ref_cnt) begin
            n_errors++; $display("FAIL rand_count[%0d] got %0d want %0d", c, illegal_count, ref_cnt);
         end
         drive_cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 29) == 0), a, d);
      end
   endtask

   task automatic test_saturation();
      logic a, d;
      for (int i = 0; i < 260; i++) drive_cycle(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, a, d);
      drive_cycle(1'b0, '0, 1'b1, 1'b0, a, d);
      n_checks++;
      if (illegal_count !== 8'd255 || ref_cnt !== 8'd255) begin
         n_errors++; $display("FAIL sat_count got %0d want 255", illegal_count);
      end
      drive_cycle(1'b0, '0, 1'b0, 1'b1, a, d);
      n_checks++;
      if (illegal_count !== 8'd255) begin n_errors++; $display("FAIL sat_after_flush got %0d want 255", illegal_count); end
   endtask

   task automatic test_async_reset();
      logic a, d;
      drive_cycle(1'b1, words[0], 1'b0, 1'b0, a, d);
      drive_cycle(1'b1, words[1], 1'b0, 1'b0, a, d);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_errors++; $display("FAIL areset_pre got v=%b r=%b want v=1 r=0", out_valid, in_ready);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd0) begin
         n_errors++; $display("FAIL areset_now got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
                              out_valid, in_ready, illegal_count);
      end
      n_checks++;
      if (dut_now !== dec_t'('0)) begin n_errors++; $display("FAIL areset_fields got %h want 0", dut_now); end
      q.delete();
      ref_cnt = 8'd0;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      ref_cnt   = 8'd0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      words[0] = 32'h00812283; k_op2[0] = 5'd1; k_rd[0] = 5'd5;
      words[1] = 32'h0061A623; k_op2[1] = 5'd2; k_rd[1] = 5'd0;
      words[2] = 32'h4030D393; k_op2[2] = 5'd3; k_rd[2] = 5'd7;
      words[3] = 32'h12345537; k_op2[3] = 5'd4; k_rd[3] = 5'd10;
      #3;
      test_reset();
      #5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_decode();
      test_illegal();
      test_backpressure();
      test_flush();
      test_random(400);
      test_saturation();
      test_async_reset();
      test_random(150);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
